sr_cmd_gen: RTL and testbench
=============================

# sr_cmd_gen

Command generator that drives the Set/Reset inputs of the cooking-enable SR latch in the microwave controller. Debounces the front-panel start/stop buttons and the door switch, converts them into single-cycle, mutually exclusive S/R pulses, and checks the latch's Q feedback to confirm that every command took effect. A command that never takes effect produces a sticky fault, and the latch is then held in reset.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive identical raw samples required before a debounced input changes. Legal range is 2 to 65535.
- `ACK_TIMEOUT`, default 3: number of cycles allowed after a pulse for `q_fb` to reach the commanded value. Legal range is 1 to 255.
- `clk` input 1: the only clock. All logic is sampled on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_start` input 1: raw start button, active-high, may bounce.
- `btn_stop` input 1: raw stop/cancel button, active-high, may bounce.
- `door_open` input 1: raw door switch. 1 means the door is open. May bounce.
- `q_fb` input 1: Q output of the downstream SR latch.
- `S` output 1: registered Set command to the latch.
- `R` output 1: registered Reset command to the latch.
- `busy` output 1: 1 while a command is in flight or the latch is running.
- `fault` output 1: sticky flag meaning the latch did not acknowledge a command.

## Operation
- **Debounce.** Each raw input has its own counter and debounced register.
  - When raw differs from debounced, the counter increments. When they are equal, the counter clears.
  - At an edge where raw still differs and the counter equals `DEBOUNCE_CYCLES-1`, the debounced value takes the raw value and the counter clears.
- **Edge detection.** `start_ev` and `stop_ev` are the rising edges of debounced start and stop. `door_ev` is the rising edge of debounced door. `door_db` is the debounced door level.
- **FSM states:** IDLE, WAIT_SET, RUN, WAIT_RST, FAULT.
- **IDLE**
  - `start_ev`, with `door_db`=0 and `stop_ev`=0: pulse S and go to WAIT_SET.
  - Otherwise `start_ev` is ignored. This covers start while the door is open and start in the same cycle as stop.
- **WAIT_SET**
  - `q_fb`=1: go to RUN.
  - `stop_ev` or `door_ev`: pulse R and go to WAIT_RST.
  - Otherwise, after `ACK_TIMEOUT` cycles without `q_fb`=1: go to FAULT.
- **RUN**
  - `stop_ev` or `door_ev`: pulse R and go to WAIT_RST.
  - `q_fb` falls with no command issued: go to IDLE. This is not a fault.
  - `start_ev`: ignored.
- **WAIT_RST**
  - `q_fb`=0: go to IDLE.
  - After `ACK_TIMEOUT` cycles without `q_fb`=0: go to FAULT.
- **FAULT**
  - R is held at 1 continuously, S at 0, `fault`=1.
  - Exited only by `rst`.
- **Invariants**
  - S and R are never 1 in the same cycle.
  - When set and reset causes coincide, reset wins.
  - Outside FAULT, every S or R pulse is exactly 1 cycle wide.
- **Status outputs.** `busy`=1 in WAIT_SET, RUN and WAIT_RST. `fault`=1 only in FAULT.
- **Timeout counter.** Width is `ceil(log2(ACK_TIMEOUT+1))` bits. It clears on entry to WAIT_SET or WAIT_RST. It saturates and never wraps.
- **Reset.**
  - While `rst`=1: state is IDLE, all debounce counters and debounced values are 0, the timeout counter is 0, and the outputs are S=0, R=1, `busy`=0, `fault`=0.
  - Holding R=1 during reset forcibly clears the latch.
  - On the first edge after `rst` falls, R drops to 0.
  - Reset asserted in the middle of a command aborts the command on the next edge.

## Timing
- **Start to S latency.** The first edge that samples raw start high is edge 1, and the input stays stable. The debounced value rises at edge `DEBOUNCE_CYCLES`. S is registered high at edge `DEBOUNCE_CYCLES+1` and low again at edge `DEBOUNCE_CYCLES+2`.
- **Stop and door latency.** Stop-to-R and door-to-R have the same `DEBOUNCE_CYCLES+1` latency.
- **Acknowledge window.** `q_fb` is checked starting at the edge after the pulse. An acknowledge that arrives on the `ACK_TIMEOUT`-th check is accepted. If it has not arrived by then, the FSM enters FAULT at the following edge. R=1 from that same edge on.
- **Bounce rejection.** Any raw glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- **Held buttons.** A held button yields exactly one event. Re-arming requires the debounced value to return to 0.

## Test plan
- **Reset then start.** `DEBOUNCE_CYCLES`=4. Apply `rst` for 2 cycles and check R=1, S=0. Release `rst` and check R=0 at the next edge. Hold `btn_start` high from edge 1 and check S=1 for exactly one cycle, at edge 5. Drive `q_fb`=1 at edge 6 and check `busy`=1 with the FSM in RUN.
- **Bounce rejection.** Toggle `btn_start` 1-0-1-0 every cycle, then hold it high for 3 cycles. Check that S stays 0 and `busy` stays 0.
- **Door interlock.** With the latch running, hold `door_open` high. Check a 1-cycle R pulse 5 edges later and return to IDLE once `q_fb`=0. Then press start with the door still open and check that S stays 0.
- **Start and stop together.** Press start and stop simultaneously from IDLE. Check that no S or R pulse is produced. Then check that a stop while in RUN gives R=1 for 1 cycle and that S=0 throughout.
- **Acknowledge timeout.** `ACK_TIMEOUT`=3. Issue start and keep `q_fb`=0. Check that `fault`=1 and R=1 continuously from the 4th edge after the S pulse. Check that a later start is ignored. Apply `rst` and check `fault`=0.
- **Reset mid-command.** Assert `rst` while in WAIT_SET. Check state IDLE, S=0, R=1, `busy`=0 at the next edge.

Source files
------------

// File: rtl/sr_cmd_gen_if.sv
// Button/door/latch bundle between the microwave front panel, the SR latch and sr_cmd_gen.
// The controller side uses the slave modport; the panel/latch side uses master.
`timescale 1ns/1ps
interface sr_cmd_gen_if;
  logic btn_start;
  logic btn_stop;
  logic door_open;
  logic q_fb;
  logic S;
  logic R;
  logic busy;
  logic fault;

  modport master (
    output btn_start, btn_stop, door_open, q_fb,
    input  S, R, busy, fault
  );

  modport slave (
    input  btn_start, btn_stop, door_open, q_fb,
    output S, R, busy, fault
  );
endinterface

// File: rtl/sr_cmd_gen.sv
// Debounces start/stop/door, issues single-cycle S/R pulses to the cooking-enable SR latch
// and checks the latch feedback; an unacknowledged command locks the latch in reset.
`timescale 1ns/1ps
module sr_cmd_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT     = 3
) (
  input  logic        clk,
  input  logic        rst,
  sr_cmd_gen_if.slave cmd_if
);

  localparam int unsigned DB_W  = 16;
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned N_IN  = 3;
  localparam int unsigned I_START = 0;
  localparam int unsigned I_STOP  = 1;
  localparam int unsigned I_DOOR  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SET,
    ST_RUN,
    ST_WAIT_RST,
    ST_FAULT
  } state_e;

  logic [N_IN-1:0]            raw;
  logic [N_IN-1:0]            db_q, db_d;
  logic [N_IN-1:0]            db_prev_q;
  logic [N_IN-1:0][DB_W-1:0]  cnt_q, cnt_d;
  logic                       start_ev, stop_ev, door_ev, door_db;

  state_e                     state_q, state_d;
  logic [TMR_W-1:0]           tmr_q, tmr_d;
  logic                       tmr_sat;
  logic                       s_q, s_d;
  logic                       r_q, r_d;
  logic                       busy_q, busy_d;
  logic                       fault_q, fault_d;

  assign raw = {cmd_if.door_open, cmd_if.btn_stop, cmd_if.btn_start};

  // Per-input debounce: count consecutive samples that disagree with the debounced level.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (raw[i] != db_q[i]) begin
        if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign start_ev = db_q[I_START] & ~db_prev_q[I_START];
  assign stop_ev  = db_q[I_STOP]  & ~db_prev_q[I_STOP];
  assign door_ev  = db_q[I_DOOR]  & ~db_prev_q[I_DOOR];
  assign door_db  = db_q[I_DOOR];
  assign tmr_sat  = (tmr_q == TMR_W'(ACK_TIMEOUT));

  // Command FSM; reset causes are tested before set/acknowledge causes.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    s_d     = 1'b0;
    r_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ev && !door_db && !stop_ev) begin
          s_d     = 1'b1;
          tmr_d   = '0;
          state_d = ST_WAIT_SET;
        end
      end
      ST_WAIT_SET: begin
        if (tmr_sat) begin
          state_d = ST_FAULT;
        end else if (stop_ev || door_ev) begin
          r_d     = 1'b1;
          tmr_d   = '0;
          state_d = ST_WAIT_RST;
        end else if (cmd_if.q_fb) begin
          state_d = ST_RUN;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_RUN: begin
        if (stop_ev || door_ev) begin
          r_d     = 1'b1;
          tmr_d   = '0;
          state_d = ST_WAIT_RST;
        end else if (!cmd_if.q_fb) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RST: begin
        if (tmr_sat) begin
          state_d = ST_FAULT;
        end else if (!cmd_if.q_fb) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_FAULT) begin
      s_d = 1'b0;
      r_d = 1'b1;
    end
    busy_d  = (state_d == ST_WAIT_SET) || (state_d == ST_RUN) || (state_d == ST_WAIT_RST);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q      <= '0;
      db_prev_q <= '0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b1;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      s_q       <= s_d;
      r_q       <= r_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
    end
  end

  assign cmd_if.S     = s_q;
  assign cmd_if.R     = r_q;
  assign cmd_if.busy  = busy_q;
  assign cmd_if.fault = fault_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: directed latency/timeout sequences, then random buttons, door and
// latch behaviour, every edge compared against a history/deadline based reference model.
`timescale 1ns/1ps
module tb_sr_cmd_gen;

  localparam int unsigned DEB = 4;
  localparam int unsigned TMO = 3;
  localparam int          N_RAND = 3000;

  typedef enum int {M_IDLE, M_ARMING, M_COOKING, M_DISARMING, M_LOCKED} mode_e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_cmd_gen_if cmd_if();

  sr_cmd_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .ACK_TIMEOUT     (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cmd_if (cmd_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int edge_no  = 0;

  // Reference model: a debounced level is whatever the last DEB raw samples unanimously agree on.
  logic [DEB-1:0] hist [3];
  logic [2:0]     m_db, m_db_old;
  mode_e          mode;
  int             deadline;
  logic           e_s, e_r, e_busy, e_fault;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s edge %0d got %b exp %b", tag, edge_no, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0] raw;
    logic start_ev, stop_ev, door_ev, door_lvl, q;
    edge_no++;
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      m_db = '0; m_db_old = '0; mode = M_IDLE;
      e_s = 1'b0; e_r = 1'b1; e_busy = 1'b0; e_fault = 1'b0;
      return;
    end
    raw      = {cmd_if.door_open, cmd_if.btn_stop, cmd_if.btn_start};
    q        = cmd_if.q_fb;
    start_ev = m_db[0] & ~m_db_old[0];
    stop_ev  = m_db[1] & ~m_db_old[1];
    door_ev  = m_db[2] & ~m_db_old[2];
    door_lvl = m_db[2];
    m_db_old = m_db;
    for (int i = 0; i < 3; i++) begin
      hist[i] = {hist[i][DEB-2:0], raw[i]};
      if (&hist[i]) m_db[i] = 1'b1;
      else if (~|hist[i]) m_db[i] = 1'b0;
    end
    e_s = 1'b0;
    e_r = 1'b0;
    case (mode)
      M_IDLE:
        if (start_ev && !door_lvl && !stop_ev) begin
          e_s = 1'b1; mode = M_ARMING; deadline = edge_no + TMO;
        end
      M_ARMING:
        if (edge_no > deadline) mode = M_LOCKED;
        else if (stop_ev || door_ev) begin
          e_r = 1'b1; mode = M_DISARMING; deadline = edge_no + TMO;
        end else if (q) mode = M_COOKING;
      M_COOKING:
        if (stop_ev || door_ev) begin
          e_r = 1'b1; mode = M_DISARMING; deadline = edge_no + TMO;
        end else if (!q) mode = M_IDLE;
      M_DISARMING:
        if (edge_no > deadline) mode = M_LOCKED;
        else if (!q) mode = M_IDLE;
      default: mode = M_LOCKED;
    endcase
    e_fault = (mode == M_LOCKED);
    e_r     = e_r | e_fault;
    e_busy  = (mode == M_ARMING) || (mode == M_COOKING) || (mode == M_DISARMING);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("S", cmd_if.S, e_s);
    check_eq("R", cmd_if.R, e_r);
    check_eq("busy", cmd_if.busy, e_busy);
    check_eq("fault", cmd_if.fault, e_fault);
  endtask

  // Random-phase stimulus state
  int         hold [3];
  logic [2:0] lvl;
  logic       lat_pend, lat_target;
  int         lat_cnt;

  initial begin
    rst = 1'b1;
    cmd_if.btn_start = 1'b0;
    cmd_if.btn_stop  = 1'b0;
    cmd_if.door_open = 1'b0;
    cmd_if.q_fb      = 1'b0;

    // Reset then start, acknowledged on the first check
    tick();
    tick();
    check_eq("rst_R", cmd_if.R, 1'b1);
    check_eq("rst_S", cmd_if.S, 1'b0);
    rst = 1'b0;
    tick();
    check_eq("rel_R", cmd_if.R, 1'b0);
    cmd_if.btn_start = 1'b1;
    for (int k = 1; k <= int'(DEB) + 2; k++) begin
      tick();
      check_eq("start_S", cmd_if.S, 1'(k == int'(DEB) + 1));
      if (k == int'(DEB) + 1) cmd_if.q_fb = 1'b1;
    end
    check_eq("run_busy", cmd_if.busy, 1'b1);
    cmd_if.btn_start = 1'b0;
    for (int k = 0; k < int'(DEB) + 2; k++) tick();

    // Stop while running
    cmd_if.btn_stop = 1'b1;
    for (int k = 1; k <= int'(DEB) + 1; k++) begin
      tick();
      check_eq("stop_R", cmd_if.R, 1'(k == int'(DEB) + 1));
    end
    cmd_if.q_fb = 1'b0;
    tick();
    check_eq("stop_R_end", cmd_if.R, 1'b0);
    check_eq("stop_idle", cmd_if.busy, 1'b0);
    cmd_if.btn_stop = 1'b0;
    for (int k = 0; k < int'(DEB) + 2; k++) tick();

    // Acknowledge timeout: latch never answers
    cmd_if.btn_start = 1'b1;
    for (int k = 1; k <= int'(DEB) + int'(TMO) + 2; k++) begin
      tick();
      if (k == int'(DEB) + 1) check_eq("to_S", cmd_if.S, 1'b1);
      if (k == int'(DEB) + int'(TMO) + 1) check_eq("to_pre_fault", cmd_if.fault, 1'b0);
      if (k == int'(DEB) + int'(TMO) + 2) begin
        check_eq("to_fault", cmd_if.fault, 1'b1);
        check_eq("to_R", cmd_if.R, 1'b1);
      end
    end
    cmd_if.btn_start = 1'b0;
    for (int k = 0; k < int'(DEB) + 2; k++) tick();
    cmd_if.btn_start = 1'b1;
    for (int k = 0; k < int'(DEB) + 3; k++) tick();
    check_eq("to_sticky", cmd_if.fault, 1'b1);
    cmd_if.btn_start = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("to_clear", cmd_if.fault, 1'b0);
    rst = 1'b0;

    // Random phase
    for (int i = 0; i < 3; i++) hold[i] = 0;
    lvl = '0;
    lat_pend = 1'b0;
    lat_target = 1'b0;
    lat_cnt = 0;
    for (int n = 0; n < N_RAND; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          lvl[i]  = (i == 2) ? 1'($urandom_range(0, 6) == 0) : 1'($urandom_range(0, 9) < 4);
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEB - 1))
                                                : int'($urandom_range(DEB, 14));
        end
        hold[i]--;
      end
      cmd_if.btn_start = lvl[0];
      cmd_if.btn_stop  = lvl[1];
      cmd_if.door_open = lvl[2];
      rst = ($urandom_range(0, 299) == 0) || (e_fault && $urandom_range(0, 15) == 0);
      tick();
      // Latch: answers S/R after a random delay, sometimes never; R held high forces Q low
      if (rst || e_fault) begin
        cmd_if.q_fb = 1'b0;
        lat_pend = 1'b0;
      end else if (e_s || e_r) begin
        lat_pend   = ($urandom_range(0, 7) != 0);
        lat_target = e_s;
        lat_cnt    = int'($urandom_range(0, TMO));
      end else if (!lat_pend && cmd_if.q_fb && $urandom_range(0, 79) == 0) begin
        cmd_if.q_fb = 1'b0;
      end
      if (lat_pend) begin
        if (lat_cnt == 0) begin
          cmd_if.q_fb = lat_target;
          lat_pend = 1'b0;
        end else begin
          lat_cnt--;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
